// File: rtl/final_proj_soc_irq_ctrl_if.sv
// ---------------------------------------------------------------------------
// final_proj_soc_irq_ctrl_if
// Avalon-MM slave bus bundle for the SoC interrupt aggregator.
//   chipselect  slave select
//   address     3-bit register word address
//   write_n     active-low write strobe
//   writedata   16-bit write data
//   readdata    16-bit registered read data (driven by the slave)
// Modports: master (CPU / bus side), slave (aggregator side).
// ---------------------------------------------------------------------------
interface final_proj_soc_irq_ctrl_if;
    logic        chipselect;
    logic [2:0]  address;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;

    modport master (
        output chipselect,
        output address,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  chipselect,
        input  address,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/final_proj_soc_irq_ctrl.sv
// ---------------------------------------------------------------------------
// final_proj_soc_irq_ctrl
// Avalon-MM interrupt aggregator. Synchronises NUM_IRQ request lines, latches
// each into a pending bit (per-line edge or level mode), masks them and drives
// one registered CPU interrupt plus a priority-encoded ACTIVE register.
//
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   bus      Avalon-MM slave (final_proj_soc_irq_ctrl_if.slave)
//   irq_in   NUM_IRQ request lines, active-high, may be asynchronous
//   irq_out  registered interrupt to CPU, active-high
//
// Register map (16-bit words):
//   0 RAW (RO)  1 PENDING (W1C)  2 MASK (RW)  3 EDGE_SEL (RW)
//   4 ACTIVE (RO, {valid,11'b0,idx})  5 FORCE (WO, write-1-sets PENDING)
//   6 HOLDOFF (RW, only with IRQ_CTRL_HOLDOFF_EN)  7 reserved
//
// Optional feature: define IRQ_CTRL_HOLDOFF_EN to add the HOLDOFF register and
// a down-counter that suppresses irq_out for HOLDOFF cycles after the last
// enabled pending bit is cleared.
// ---------------------------------------------------------------------------
module final_proj_soc_irq_ctrl #(
    parameter int NUM_IRQ     = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    final_proj_soc_irq_ctrl_if.slave   bus,
    input  logic [NUM_IRQ-1:0]         irq_in,
    output logic                       irq_out
);

    localparam logic [2:0] ADDR_RAW     = 3'd0;
    localparam logic [2:0] ADDR_PENDING = 3'd1;
    localparam logic [2:0] ADDR_MASK    = 3'd2;
    localparam logic [2:0] ADDR_EDGE    = 3'd3;
    localparam logic [2:0] ADDR_ACTIVE  = 3'd4;
    localparam logic [2:0] ADDR_FORCE   = 3'd5;
    localparam logic [2:0] ADDR_HOLDOFF = 3'd6;

    // Zero-extend a per-line vector to a 16-bit register word.
    function automatic logic [15:0] ext16(input logic [NUM_IRQ-1:0] v);
        logic [15:0] r;
        r = '0;
        r[NUM_IRQ-1:0] = v;
        return r;
    endfunction

    logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
    logic [NUM_IRQ-1:0] sync_d [SYNC_STAGES];
    logic [NUM_IRQ-1:0] prev_q, prev_d;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] mask_q, mask_d;
    logic [NUM_IRQ-1:0] edge_sel_q, edge_sel_d;
    logic [15:0]        readdata_q, readdata_d;
    logic               irq_out_q, irq_out_d;

    logic [NUM_IRQ-1:0] sync;
    logic [NUM_IRQ-1:0] wdata;
    logic [NUM_IRQ-1:0] set_vec;
    logic [NUM_IRQ-1:0] clr_vec;
    logic [NUM_IRQ-1:0] pm;
    logic               pm_any;
    logic [3:0]         act_idx;
    logic               wr_en;
    logic [15:0]        holdoff_rd;
    logic               irq_allow;

    assign wr_en = bus.chipselect && !bus.write_n;
    assign wdata = NUM_IRQ'(bus.writedata);
    assign sync  = sync_q[SYNC_STAGES-1];
    assign pm    = pending_q & mask_q;
    assign pm_any = |pm;

    // Synchroniser chain; stage 0 samples the raw asynchronous input.
    always_comb begin
        sync_d[0] = irq_in;
        for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
    end

    // prev tracks sync in every mode, so switching a line to edge mode while
    // it is already high never manufactures an edge.
    always_comb begin
        prev_d     = sync;
        mask_d     = (wr_en && bus.address == ADDR_MASK) ? wdata : mask_q;
        edge_sel_d = (wr_en && bus.address == ADDR_EDGE) ? wdata : edge_sel_q;
        clr_vec    = (wr_en && bus.address == ADDR_PENDING) ? wdata : '0;
        set_vec    = (edge_sel_q & sync & ~prev_q) | (~edge_sel_q & sync);
        if (wr_en && bus.address == ADDR_FORCE) begin
            set_vec = set_vec | wdata;
        end
        // Set is OR-ed after the clear so a simultaneous event is never lost.
        pending_d  = set_vec | (pending_q & ~clr_vec);
    end

    // Lowest set bit of PENDING&MASK wins.
    always_comb begin
        act_idx = '0;
        for (int i = NUM_IRQ-1; i >= 0; i--) begin
            if (pm[i]) begin
                act_idx = 4'(i);
            end
        end
    end

    always_comb begin
        case (bus.address)
            ADDR_RAW:     readdata_d = ext16(sync);
            ADDR_PENDING: readdata_d = ext16(pending_q);
            ADDR_MASK:    readdata_d = ext16(mask_q);
            ADDR_EDGE:    readdata_d = ext16(edge_sel_q);
            ADDR_ACTIVE:  readdata_d = pm_any ? {1'b1, 11'b0, act_idx} : 16'h0000;
            ADDR_HOLDOFF: readdata_d = holdoff_rd;
            default:      readdata_d = 16'h0000;
        endcase
        irq_out_d = pm_any && irq_allow;
    end

`ifdef IRQ_CTRL_HOLDOFF_EN
    logic [15:0] holdoff_q, holdoff_d;
    logic [15:0] cnt_q, cnt_d;
    logic        pm_fall;

    // The counter reloads only on a nonzero->zero transition of the enabled
    // pending set; rewriting HOLDOFF leaves a running count alone.
    always_comb begin
        holdoff_d = (wr_en && bus.address == ADDR_HOLDOFF) ? bus.writedata : holdoff_q;
        pm_fall   = pm_any && !(|(pending_d & mask_d));
        if (pm_fall) begin
            cnt_d = holdoff_q;
        end else if (cnt_q != 16'd0) begin
            cnt_d = cnt_q - 16'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Gating on the next count keeps irq_out low exactly while the counter
    // register is nonzero.
    assign holdoff_rd = holdoff_q;
    assign irq_allow  = (cnt_d == 16'd0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            holdoff_q <= '0;
            cnt_q     <= '0;
        end else begin
            holdoff_q <= holdoff_d;
            cnt_q     <= cnt_d;
        end
    end
`else
    assign holdoff_rd = 16'h0000;
    assign irq_allow  = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            prev_q     <= '0;
            pending_q  <= '0;
            mask_q     <= '0;
            edge_sel_q <= '0;
            readdata_q <= '0;
            irq_out_q  <= 1'b0;
        end else begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_d[s];
            end
            prev_q     <= prev_d;
            pending_q  <= pending_d;
            mask_q     <= mask_d;
            edge_sel_q <= edge_sel_d;
            readdata_q <= readdata_d;
            irq_out_q  <= irq_out_d;
        end
    end

    assign bus.readdata = readdata_q;
    assign irq_out      = irq_out_q;

endmodule

// File: tb/tb_final_proj_soc_irq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_final_proj_soc_irq_ctrl
// Directed, table-driven bench for the interrupt aggregator, with hand-written
// sequences for edge/level latching, W1C collision, holdoff and async reset.
// ---------------------------------------------------------------------------
module tb_final_proj_soc_irq_ctrl;
    localparam int NUM_IRQ = 8;
    localparam int SYNC    = 2;

    localparam int OP_RD      = 0;
    localparam int OP_WR      = 1;
    localparam int OP_WR_NOCS = 2;

    typedef struct {
        int          op;
        logic [2:0]  addr;
        logic [15:0] data;
        logic [15:0] exp;
        bit          chk_irq;
        bit          exp_irq;
    } vec_t;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic [NUM_IRQ-1:0] irq_in = '0;
    logic               irq_out;

    final_proj_soc_irq_ctrl_if bus();

    final_proj_soc_irq_ctrl #(.NUM_IRQ(NUM_IRQ), .SYNC_STAGES(SYNC)) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .irq_in  (irq_in),
        .irq_out (irq_out)
    );

    always #5 clk = ~clk;

    int   n_chk  = 0;
    int   n_pass = 0;
    vec_t tab[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    endtask

    task automatic add(input int op, input logic [2:0] a, input logic [15:0] d,
                       input logic [15:0] e, input bit ci, input bit ei);
        vec_t v;
        v.op = op; v.addr = a; v.data = d; v.exp = e; v.chk_irq = ci; v.exp_irq = ei;
        tab.push_back(v);
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d, input bit cs);
        @(negedge clk);
        bus.chipselect = cs;
        bus.address    = a;
        bus.write_n    = 1'b0;
        bus.writedata  = d;
        @(posedge clk);
        #1;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [15:0] d);
        @(negedge clk);
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        bus.address    = a;
        @(posedge clk);
        #1;
        d = bus.readdata;
    endtask

    initial begin
        logic [15:0] rv;
        int          lat;
        bit          hold_en;

`ifdef IRQ_CTRL_HOLDOFF_EN
        hold_en = 1'b1;
`else
        hold_en = 1'b0;
`endif
        bus.chipselect = 1'b0;
        bus.address    = 3'd0;
        bus.write_n    = 1'b1;
        bus.writedata  = 16'h0000;

        // Reset read-back of the whole map.
        for (int a = 0; a < 8; a++) add(OP_RD, 3'(a), 16'h0, 16'h0000, 1, 0);
        // Priority, masking, register widths, write qualification.
        add(OP_WR,      3'd2, 16'h0020, 16'h0, 0, 0);
        add(OP_WR,      3'd5, 16'h0028, 16'h0, 0, 0);
        add(OP_RD,      3'd1, 16'h0,    16'h0028, 1, 1);
        add(OP_RD,      3'd4, 16'h0,    16'h8005, 1, 1);
        add(OP_RD,      3'd5, 16'h0,    16'h0000, 0, 0);
        add(OP_WR,      3'd2, 16'h0028, 16'h0, 0, 0);
        add(OP_RD,      3'd4, 16'h0,    16'h8003, 1, 1);
        add(OP_WR_NOCS, 3'd2, 16'h00FF, 16'h0, 0, 0);
        add(OP_RD,      3'd2, 16'h0,    16'h0028, 0, 0);
        add(OP_WR,      3'd3, 16'hFFFF, 16'h0, 0, 0);
        add(OP_RD,      3'd3, 16'h0,    16'h00FF, 0, 0);
        add(OP_WR,      3'd0, 16'hFFFF, 16'h0, 0, 0);
        add(OP_RD,      3'd0, 16'h0,    16'h0000, 0, 0);
        add(OP_WR,      3'd1, 16'h0008, 16'h0, 0, 0);
        add(OP_RD,      3'd1, 16'h0,    16'h0020, 0, 0);
        add(OP_RD,      3'd4, 16'h0,    16'h8005, 1, 1);
        add(OP_WR,      3'd1, 16'h0020, 16'h0, 0, 0);
        add(OP_RD,      3'd1, 16'h0,    16'h0000, 1, 0);
        add(OP_RD,      3'd4, 16'h0,    16'h0000, 1, 0);
        add(OP_WR,      3'd7, 16'hFFFF, 16'h0, 0, 0);
        add(OP_RD,      3'd7, 16'h0,    16'h0000, 0, 0);
        add(OP_RD,      3'd6, 16'h0,    16'h0000, 0, 0);
        add(OP_WR,      3'd2, 16'h0000, 16'h0, 0, 0);
        add(OP_WR,      3'd3, 16'h0000, 16'h0, 0, 0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < tab.size(); i++) begin
            if (tab[i].op == OP_RD) begin
                rd(tab[i].addr, rv);
                check($sformatf("vec%0d_rd_a%0d", i, tab[i].addr), rv, tab[i].exp);
                if (tab[i].chk_irq)
                    check($sformatf("vec%0d_irq", i), {15'b0, irq_out}, {15'b0, tab[i].exp_irq});
            end else begin
                wr(tab[i].addr, tab[i].data, tab[i].op == OP_WR);
            end
        end

        // Edge mode on line 0: latency, ACTIVE, W1C with source held high.
        wr(3'd2, 16'h0001, 1'b1);
        wr(3'd3, 16'h0001, 1'b1);
        @(negedge clk);
        irq_in[0] = 1'b1;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (irq_out && lat == 0) lat = k;
        end
        check("edge_latency", 16'(lat), 16'(SYNC + 2));
        rd(3'd1, rv); check("edge_pending", rv, 16'h0001);
        rd(3'd4, rv); check("edge_active", rv, 16'h8000);
        wr(3'd1, 16'h0001, 1'b1);
        rd(3'd1, rv); check("edge_w1c_pending", rv, 16'h0000);
        check("edge_w1c_irq", {15'b0, irq_out}, 16'h0000);
        repeat (3) @(posedge clk);
        rd(3'd1, rv); check("edge_no_reset", rv, 16'h0000);
        @(negedge clk);
        irq_in[0] = 1'b0;
        repeat (4) @(posedge clk);

        // Level mode on line 2.
        wr(3'd3, 16'h0000, 1'b1);
        wr(3'd2, 16'h0004, 1'b1);
        @(negedge clk);
        irq_in[2] = 1'b1;
        repeat (6) @(posedge clk);
        wr(3'd1, 16'h0004, 1'b1);
        rd(3'd1, rv); check("level_w1c_held", rv, 16'h0004);
        check("level_irq_held", {15'b0, irq_out}, 16'h0001);
        @(negedge clk);
        irq_in[2] = 1'b0;
        repeat (4) @(posedge clk);
        wr(3'd1, 16'h0004, 1'b1);
        rd(3'd1, rv); check("level_w1c_low", rv, 16'h0000);
        check("level_irq_low", {15'b0, irq_out}, 16'h0000);

        // Edge on line 1 lands on the same clock as a W1C of line 1.
        wr(3'd3, 16'h0002, 1'b1);
        wr(3'd2, 16'h0002, 1'b1);
        wr(3'd5, 16'h0002, 1'b1);
        rd(3'd1, rv); check("coll_forced", rv, 16'h0002);
        @(negedge clk);
        irq_in[1] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        wr(3'd1, 16'h0002, 1'b1);
        rd(3'd1, rv); check("coll_set_wins", rv, 16'h0002);
        wr(3'd1, 16'h0002, 1'b1);
        rd(3'd1, rv); check("coll_clear_after", rv, 16'h0000);
        @(negedge clk);
        irq_in[1] = 1'b0;
        wr(3'd2, 16'h0000, 1'b1);
        wr(3'd3, 16'h0000, 1'b1);
        repeat (4) @(posedge clk);

        // Holdoff: clear the last pending bit, new edge arrives 3 cycles later.
        if (hold_en) begin
            wr(3'd6, 16'd10, 1'b1);
            rd(3'd6, rv); check("holdoff_reg", rv, 16'd10);
        end
        wr(3'd2, 16'h0001, 1'b1);
        wr(3'd3, 16'h0001, 1'b1);
        wr(3'd5, 16'h0001, 1'b1);
        wr(3'd1, 16'h0001, 1'b1);
        @(negedge clk);
        irq_in[0] = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("hold_irq_k%0d", k), {15'b0, irq_out},
                  {15'b0, (hold_en ? (k >= 10) : (k >= 4))});
            check($sformatf("hold_pend_k%0d", k), bus.readdata,
                  (k >= 4) ? 16'h0001 : 16'h0000);
        end

        // Asynchronous reset in the middle of activity.
        @(negedge clk);
        irq_in  = '0;
        reset_n = 1'b0;
        #1;
        check("async_rst_irq", {15'b0, irq_out}, 16'h0000);
        check("async_rst_rdata", bus.readdata, 16'h0000);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        rd(3'd2, rv); check("post_rst_mask", rv, 16'h0000);
        rd(3'd1, rv); check("post_rst_pending", rv, 16'h0000);
        check("post_rst_irq", {15'b0, irq_out}, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
